// File: rtl/mc_maindec_pkg.sv
// Shared MIPS declarations: instruction fields plus the multicycle controller's
// state, mux-select and error encodings.
package mips_decls_p;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_JAL   = 6'b000011,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef enum logic [5:0] {
        F_JR  = 6'b001000,
        F_ADD = 6'b100000,
        F_SUB = 6'b100010,
        F_AND = 6'b100100,
        F_OR  = 6'b100101,
        F_SLT = 6'b101010
    } funct_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_ALUWB, S_BEQ, S_ADDIEX, S_ADDIWB,
        S_J, S_JAL, S_JR, S_ERR
    } statetype_t;

    typedef enum logic [1:0] {
        SRCB_B     = 2'b00,
        SRCB_FOUR  = 2'b01,
        SRCB_IMM   = 2'b10,
        SRCB_IMMSH = 2'b11
    } alusrcb_t;

    typedef enum logic [1:0] {
        PC_ALURESULT = 2'b00,
        PC_ALUOUT    = 2'b01,
        PC_JUMP      = 2'b10,
        PC_RS        = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

    // States that hold the shared memory port and are guarded by the watchdog
    function automatic logic is_mem_state(statetype_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_maindec_wait_timer.sv
// Saturating wait-cycle counter for memory states; timeout flags the limit cycle.
module mc_wait_timer #(
    parameter  int MAX_WAIT = 15,
    localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_reg;

    // Count stalled memory cycles, holding at the limit instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign timeout = (count_reg == LIMIT);

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller with handshaked memory port, watchdog
// timeout and sticky error trap.
module mc_maindec
    import mips_decls_p::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       jal,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       retire,
    output logic [1:0] err
);

    statetype_t state_reg, state_next;
    err_t       err_reg, err_next;
    logic       in_mem;
    logic       timeout;

    // Counter restarts whenever a memory access completes or we are elsewhere,
    // so back-to-back memory states (MEMWR -> FETCH) each get a full budget.
    assign in_mem = is_mem_state(state_reg);

    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_mem || mem_ready),
        .enable  (in_mem && !mem_ready),
        .timeout (timeout)
    );

    // State and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
            err_reg   <= ERR_NONE;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
        end
    end

    assign err = err_reg;

    // Next state and datapath strobes; everything is forced low while reset is high
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        jal        = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PC_ALURESULT;
        aluop      = 2'b00;
        retire     = 1'b0;
        state_next = state_reg;
        err_next   = err_reg;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = SRCB_FOUR;
                    if (mem_ready) begin
                        irwrite    = 1'b1;
                        pcwrite    = 1'b1;
                        state_next = S_DECODE;
                    end else if (timeout) begin
                        state_next = S_ERR;
                        err_next   = ERR_TIMEOUT;
                    end
                end
                S_DECODE: begin
                    alusrcb = SRCB_IMMSH;
                    case (opcode)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_RTYPE:     state_next = (funct == F_JR) ? S_JR : S_RTYPEEX;
                        OP_BEQ:       state_next = S_BEQ;
                        OP_ADDI:      state_next = S_ADDIEX;
                        OP_J:         state_next = S_J;
                        OP_JAL:       state_next = S_JAL;
                        default: begin
                            state_next = S_ERR;
                            err_next   = ERR_ILLEGAL;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_MEMWB;
                    end else if (timeout) begin
                        state_next = S_ERR;
                        err_next   = ERR_TIMEOUT;
                    end
                end
                S_MEMWB: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    if (mem_ready) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else if (timeout) begin
                        state_next = S_ERR;
                        err_next   = ERR_TIMEOUT;
                    end
                end
                S_RTYPEEX: begin
                    alusrca    = 1'b1;
                    aluop      = 2'b10;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    regwrite   = 1'b1;
                    regdst     = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_BEQ: begin
                    alusrca    = 1'b1;
                    aluop      = 2'b01;
                    branch     = 1'b1;
                    pcsrc      = PC_ALUOUT;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_ADDIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = SRCB_IMM;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    regwrite   = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_J: begin
                    pcwrite    = 1'b1;
                    pcsrc      = PC_JUMP;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_JAL: begin
                    pcwrite    = 1'b1;
                    pcsrc      = PC_JUMP;
                    regwrite   = 1'b1;
                    jal        = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_JR: begin
                    pcwrite    = 1'b1;
                    pcsrc      = PC_RS;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
                S_ERR: begin
                    state_next = S_ERR;
                end
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: directed corner cases then randomized
// instruction streams with random memory latency, checked every cycle against
// an instruction-level reference of the expected strobe sequence.
module tb_mc_maindec;
    import mips_decls_p::*;

    localparam int MW = 3;

    typedef struct packed {
        logic       mem_req, iord, memwrite, irwrite, pcwrite, branch;
        logic       regwrite, regdst, memtoreg, jal, alusrca;
        logic [1:0] alusrcb, pcsrc, aluop;
        logic       retire;
        logic [1:0] err;
    } outs_t;

    logic       clk, reset, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, iord, memwrite, irwrite, pcwrite, branch;
    logic       regwrite, regdst, memtoreg, jal, alusrca, retire;
    logic [1:0] alusrcb, pcsrc, aluop, err;
    outs_t      obs;

    int vectors    = 0;
    int miscompares = 0;
    logic [1:0] err_model = 2'b00;

    mc_maindec #(.MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
        .branch(branch), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .jal(jal), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .retire(retire), .err(err)
    );

    assign obs = {mem_req, iord, memwrite, irwrite, pcwrite, branch,
                  regwrite, regdst, memtoreg, jal, alusrca,
                  alusrcb, pcsrc, aluop, retire, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic bit is_legal(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_J) || (op == OP_JAL);
    endfunction

    // One clock: apply inputs, compare at the falling edge, return just after the rising edge
    task automatic chk(input outs_t e, input string tag, input logic rdy, input bit keep_op);
        mem_ready = rdy;
        if (!keep_op) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
        end
        @(negedge clk);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        outs_t e;
        reset     = 1'b1;
        err_model = 2'b00;
        e = '0;
        chk(e, "in_reset", 1'($urandom), 0);
        chk(e, "in_reset", 1'($urandom), 0);
        reset = 1'b0;
    endtask

    // Error trap: all strobes low, code held, until reset
    task automatic err_hold();
        outs_t e;
        e = '0;
        e.err = err_model;
        for (int i = 0; i < 3; i++) chk(e, "err_hold", 1'($urandom), 0);
        do_reset();
    endtask

    // Memory access: 'waits' idle cycles before ready; more than MW waits times out
    task automatic mem_phase(input outs_t base, input outs_t on_ready, input int waits,
                             input string tag, input bit keep_op, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i <= MW; i++) begin
            if (i == waits) begin
                chk(base | on_ready, tag, 1'b1, keep_op);
                return;
            end
            chk(base, tag, 1'b0, keep_op);
        end
        timed_out = 1'b1;
        err_model = ERR_TIMEOUT;
    endtask

    // Reference sequence for one instruction
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
        outs_t e, r;
        bit    to;
        e = '0; e.mem_req = 1'b1; e.alusrcb = 2'b01;
        r = '0; r.irwrite = 1'b1; r.pcwrite = 1'b1;
        mem_phase(e, r, fw, "fetch", 0, to);
        if (to) begin err_hold(); return; end

        opcode = op; funct = fn;
        e = '0; e.alusrcb = 2'b11;
        chk(e, "decode", 1'($urandom), 1);
        if (!is_legal(op)) begin
            err_model = ERR_ILLEGAL;
            err_hold();
            return;
        end

        e = '0;
        if (op == OP_LW || op == OP_SW) begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
            chk(e, "memadr", 1'($urandom), 1);
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
            r = '0;
            if (op == OP_SW) begin
                e.memwrite = 1'b1; r.retire = 1'b1;
                mem_phase(e, r, mw, "memwr", 0, to);
                if (to) err_hold();
            end else begin
                mem_phase(e, r, mw, "memrd", 0, to);
                if (to) begin err_hold(); return; end
                e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.retire = 1'b1;
                chk(e, "memwb", 1'($urandom), 0);
            end
        end else if (op == OP_RTYPE && fn == F_JR) begin
            e.pcwrite = 1'b1; e.pcsrc = 2'b11; e.retire = 1'b1;
            chk(e, "jr", 1'($urandom), 0);
        end else if (op == OP_RTYPE) begin
            e.alusrca = 1'b1; e.aluop = 2'b10;
            chk(e, "rtype_ex", 1'($urandom), 0);
            e = '0; e.regwrite = 1'b1; e.regdst = 1'b1; e.retire = 1'b1;
            chk(e, "alu_wb", 1'($urandom), 0);
        end else if (op == OP_ADDI) begin
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
            chk(e, "addi_ex", 1'($urandom), 0);
            e = '0; e.regwrite = 1'b1; e.retire = 1'b1;
            chk(e, "addi_wb", 1'($urandom), 0);
        end else if (op == OP_BEQ) begin
            e.alusrca = 1'b1; e.aluop = 2'b01; e.branch = 1'b1; e.pcsrc = 2'b01; e.retire = 1'b1;
            chk(e, "beq", 1'($urandom), 0);
        end else begin
            e.pcwrite = 1'b1; e.pcsrc = 2'b10; e.retire = 1'b1;
            if (op == OP_JAL) begin e.regwrite = 1'b1; e.jal = 1'b1; end
            chk(e, (op == OP_JAL) ? "jal" : "j", 1'($urandom), 0);
        end
    endtask

    initial begin
        outs_t      e;
        logic [5:0] op, fn;
        int         k, fw, mw;

        reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
        @(posedge clk);
        #1;
        e = '0;
        chk(e, "reset_state", 1'b1, 0);
        chk(e, "reset_state", 1'b1, 0);
        reset = 1'b0;

        // Directed corners
        run_instr(OP_LW, F_ADD, 0, 0);          // 5-cycle lw
        run_instr(OP_SW, F_ADD, 0, MW);         // ready on limit cycle in MEMWR
        run_instr(OP_RTYPE, F_ADD, 0, 0);
        run_instr(OP_RTYPE, F_JR, 0, 0);        // jr: pcsrc=11 in cycle 3
        run_instr(OP_ADDI, F_ADD, MW, 0);       // ready on limit cycle in FETCH
        run_instr(OP_LW, F_ADD, MW + 1, 0);     // fetch timeout -> err 10
        run_instr(6'b111111, F_ADD, 0, 0);      // illegal opcode -> err 01
        run_instr(OP_LW, F_ADD, 0, MW + 1);     // read timeout
        run_instr(OP_SW, F_ADD, 1, MW + 1);     // write timeout

        // jal, then reset in the middle of the next lw's read wait
        run_instr(OP_JAL, F_ADD, 0, 0);
        e = '0; e.mem_req = 1'b1; e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcwrite = 1'b1;
        chk(e, "mid_fetch", 1'b1, 0);
        opcode = OP_LW;
        e = '0; e.alusrcb = 2'b11;
        chk(e, "mid_decode", 1'b0, 1);
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
        chk(e, "mid_memadr", 1'b0, 1);
        e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
        chk(e, "mid_memrd", 1'b0, 0);
        reset = 1'b1;
        e = '0;
        chk(e, "mid_reset", 1'b1, 0);
        reset = 1'b0;
        run_instr(OP_BEQ, F_ADD, 0, 0);

        // Randomized instruction stream with random memory latency
        for (int n = 0; n < 200; n++) begin
            k  = $urandom_range(0, 9);
            fn = 6'($urandom);
            if (fn == F_JR) fn = F_ADD;
            case (k)
                0, 9: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_RTYPE;
                3: begin op = OP_RTYPE; fn = F_JR; end
                4: op = OP_BEQ;
                5: op = OP_ADDI;
                6: op = OP_J;
                7: op = OP_JAL;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            fw = ($urandom_range(0, 15) == 0) ? MW + 1 : $urandom_range(0, MW);
            mw = ($urandom_range(0, 15) == 0) ? MW + 1 : $urandom_range(0, MW);
            run_instr(op, fn, fw, mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
